imem_fetch_ctrl: RTL and testbench

Instruction-fetch controller that sequences the instruction memory for the pipeline front end. It owns the program counter, drives the memory address, and captures returned words with their PC into a 2-entry prefetch FIFO. Decode consumes that FIFO through a valid/ready handshake. The block also applies branch redirects, detects the end of the loaded program, drains, and reports completion.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/imem_fetch_ctrl_if.sv | 27 ++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/imem_fetch_ctrl.sv | 106 ++++++++++
 tb/tb_imem_fetch_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
//   fetch_state_t : controller FSM states
//   fetch_entry_t : one prefetch FIFO entry, {pc, instr}
//   NOP_INSTR     : value shown on if_instr before anything has been fetched
//   PC_STEP       : byte increment between sequential instruction words
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0800_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory port, decode handshake and the
// redirect request from execute.
//   master : the fetch controller (drives imem_addr and the if_* head outputs)
//   slave  : memory / decode / execute environment
interface imem_fetch_ctrl_if;
  import fetch_pkg::*;

  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_addr, if_valid, if_instr, if_pc,
    input  imem_rdata, id_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc,
    output imem_rdata, id_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO with synchronous flush.
//   clk, reset  : clock, synchronous active-high reset
//   flush       : drop all entries (wins over push/pop)
//   push, wdata : enqueue; allowed while full only together with pop
//   pop         : dequeue head; caller guarantees not empty
//   rdata       : head entry, or the last head shown once the FIFO is empty
//   full, empty : occupancy flags; last = exactly one entry
module fetch_fifo #(
  parameter int             DEPTH     = 2,
  parameter int             W         = 64,
  parameter logic [W-1:0]   HOLD_INIT = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic         last
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wp, rp;
  logic [AW:0]             cnt;
  logic [W-1:0]            hold_q;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign last  = (cnt == (AW+1)'(1));
  // Head output never goes X: when empty it keeps showing the last head.
  assign rdata = empty ? hold_q : mem[rp];

  always_ff @(posedge clk) begin
    if (reset) begin
      wp     <= '0;
      rp     <= '0;
      cnt    <= '0;
      hold_q <= HOLD_INIT;
    end else begin
      if (!empty) hold_q <= mem[rp];
      if (flush) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (push) begin
          mem[wp] <= wdata;
          wp      <= wp + AW'(1);
        end
        if (pop) rp <= rp + AW'(1);
        case ({push, pop})
          2'b10:   cnt <= cnt + (AW+1)'(1);
          2'b01:   cnt <= cnt - (AW+1)'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives instruction memory,
// captures {pc, instr} into a prefetch FIFO consumed by decode, applies
// branch redirects and reports when the loaded program has been drained.
//   clk, reset  : clock, synchronous active-high reset
//   start       : leave IDLE and begin fetching at the current PC
//   bus         : memory port, decode handshake, redirect (master side)
//   done        : program fully fetched and drained
//   fetch_count : instructions enqueued since reset, saturating
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [20:0] LAST_WORD  = 21'd9,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  imem_fetch_ctrl_if.master  bus,
  output logic               done,
  output logic [15:0]        fetch_count
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         redir, push, pop, flush;
  logic         full, empty, last;
  fetch_entry_t wentry, head;
  logic         unused_redir_lsb;

  assign unused_redir_lsb = ^bus.redirect_pc[1:0];

  // Redirects only matter once fetching has been started.
  assign redir = bus.redirect_valid && (state_q != IDLE);
  assign pop   = bus.if_valid && bus.id_ready && !redir;

  assign wentry = '{pc: pc_q, instr: bus.imem_rdata};

  fetch_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .W         ($bits(fetch_entry_t)),
    .HOLD_INIT ({32'h0, NOP_INSTR})
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .last  (last)
  );

  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = !empty;
  assign bus.if_pc     = head.pc;
  assign bus.if_instr  = head.instr;
  assign done          = (state_q == DONE);
  assign fetch_count   = cnt_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (redir) begin
      flush   = 1'b1;
      pc_d    = {bus.redirect_pc[31:2], 2'b00};
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE:  if (start) state_d = RUN;
        RUN: begin
          if (pc_q[22:2] > LAST_WORD) begin
            state_d = DRAIN;
          end else if (!full || pop) begin
            push = 1'b1;
            pc_d = pc_q + PC_STEP;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          end
        end
        // Finish as soon as the FIFO is empty after this edge.
        DRAIN: if (empty || (last && pop)) state_d = DONE;
        DONE:  ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        done;
  logic [15:0] fetch_count;

  imem_fetch_ctrl_if bus();

  imem_fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .LAST_WORD  (21'd9),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bus         (bus),
    .done        (done),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  // Memory contents: word at address a is C0DE_0000 ^ a (RAM[5] = C0DE_0014).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  int          cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (!done && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic push_exp(input logic [31:0] first, input logic [31:0] lst);
    for (logic [31:0] p = first; p <= lst; p += 32'd4) exp_q.push_back(p);
  endtask

  // Scoreboard monitor: every instruction decode accepts is checked in order.
  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (!reset && bus.if_valid && bus.id_ready && !bus.redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc %h expected none", bus.if_pc);
      end else begin
        e = exp_q.pop_front();
        chk("pop_pc", bus.if_pc, e);
        chk("pop_instr", bus.if_instr, mem_word(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset              = 1'b1;
    start              = 1'b0;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    tick();
    tick();
    chk("rst_if_valid", bus.if_valid, 32'd0);
    chk("rst_if_instr", bus.if_instr, 32'h0800_0000);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    chk("rst_done", done, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    reset = 1'b0;

    // Full program streamed with decode always ready.
    push_exp(32'h00, 32'h24);
    bus.id_ready = 1'b1;
    start        = 1'b1;
    tick();
    start = 1'b0;
    chk("start_lat_valid", bus.if_valid, 32'd0);
    wait_done(40, cyc);
    chk("run_done_cycles", cyc, 32'd12);
    chk("run_count", fetch_count, 32'd10);
    chk("run_addr_held", bus.imem_addr, 32'd40);
    chk("run_drained", bus.if_valid, 32'd0);

    // Redirect from DONE; low address bits must be ignored (0x0F -> 0x0C).
    push_exp(32'h0C, 32'h24);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_000F;
    tick();
    bus.redirect_valid = 1'b0;
    chk("done_redir_drop", done, 32'd0);
    chk("done_redir_addr", bus.imem_addr, 32'h0C);
    wait_done(40, cyc);
    chk("done_redir_cycles", cyc, 32'd9);
    chk("done_redir_count", fetch_count, 32'd17);

    // Backpressure: FIFO fills with 0 and 4, PC stalls at 8.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_count", fetch_count, 32'd0);
    chk("rst2_done", done, 32'd0);
    bus.id_ready = 1'b0;
    start        = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("stall_addr", bus.imem_addr, 32'h08);
    chk("stall_count", fetch_count, 32'd2);
    chk("stall_valid", bus.if_valid, 32'd1);
    chk("stall_head", bus.if_pc, 32'h00);
    push_exp(32'h00, 32'h04);
    bus.id_ready = 1'b1;
    tick();
    chk("release_head4", bus.if_pc, 32'h04);
    tick();
    bus.id_ready = 1'b0;
    chk("release_head8", bus.if_pc, 32'h08);
    chk("release_count", fetch_count, 32'd4);
    chk("release_addr", bus.imem_addr, 32'h10);

    // Redirect while FIFO holds 8 and 12.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h14;
    tick();
    bus.redirect_valid = 1'b0;
    chk("redir_flush_valid", bus.if_valid, 32'd0);
    chk("redir_addr", bus.imem_addr, 32'h14);
    tick();
    chk("redir_tgt_valid", bus.if_valid, 32'd1);
    chk("redir_tgt_pc", bus.if_pc, 32'h14);
    chk("redir_tgt_instr", bus.if_instr, 32'hC0DE_0014);
    push_exp(32'h14, 32'h24);
    bus.id_ready = 1'b1;
    wait_done(40, cyc);
    chk("redir_done", done, 32'd1);
    chk("redir_count", fetch_count, 32'd9);

    // Redirect coinciding with end-of-program detection: redirect wins.
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h24;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h08;
    tick();
    bus.redirect_valid = 1'b0;
    chk("race_valid", bus.if_valid, 32'd0);
    chk("race_addr", bus.imem_addr, 32'h08);
    tick();
    chk("race_fetch_valid", bus.if_valid, 32'd1);
    chk("race_fetch_pc", bus.if_pc, 32'h08);
    chk("race_count", fetch_count, 32'd11);
    tick();

    // Reset mid-RUN together with start: reset wins, stays IDLE.
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("mid_rst_addr", bus.imem_addr, 32'h0);
    chk("mid_rst_valid", bus.if_valid, 32'd0);
    chk("mid_rst_count", fetch_count, 32'd0);
    chk("mid_rst_instr", bus.if_instr, 32'h0800_0000);
    chk("mid_rst_pc", bus.if_pc, 32'h0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h20;
    tick();
    tick();
    bus.redirect_valid = 1'b0;
    chk("idle_redir_ignored", bus.imem_addr, 32'h0);
    chk("idle_no_fetch", bus.if_valid, 32'd0);

    // Redirect to an out-of-program address: drain straight to DONE.
    start = 1'b1;
    tick();
    start              = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    chk("oop_addr", bus.imem_addr, 32'hFFFF_FFFC);
    chk("oop_valid", bus.if_valid, 32'd0);
    wait_done(10, cyc);
    chk("oop_done_cycles", cyc, 32'd2);
    chk("oop_count", fetch_count, 32'd0);
    chk("oop_empty", bus.if_valid, 32'd0);
    chk("oop_addr_held", bus.imem_addr, 32'hFFFF_FFFC);

    tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
